// File: rtl/bp_fe_scan_sequencer.sv
// Front-end instruction queue with a scan stage on the head entry. Consumed taken jumps and
// backward branches latch their target and hold a redirect request until the PC generator accepts it.
package bp_fe_scan_pkg;
    typedef enum logic [1:0] {
        e_default    = 2'd0,
        e_rvi_branch = 2'd1,
        e_rvi_jal    = 2'd2,
        e_rvi_jalr   = 2'd3
    } bp_fe_instr_scan_class_e;
endpackage

module bp_fe_scan_sequencer
    import bp_fe_scan_pkg::*;
#(
    parameter eaddr_width_p = "inv",
    parameter instr_width_p = "inv",
    parameter fifo_els_p    = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         fetch_v_i,
    input  logic [eaddr_width_p-1:0]     fetch_pc_i,
    input  logic [instr_width_p-1:0]     fetch_instr_i,
    output logic                         fetch_ready_o,
    output logic                         instr_v_o,
    output logic [eaddr_width_p-1:0]     instr_pc_o,
    output logic [instr_width_p-1:0]     instr_o,
    output bp_fe_instr_scan_class_e      instr_class_o,
    output logic                         instr_compressed_o,
    input  logic                         instr_yumi_i,
    output logic                         redirect_v_o,
    output logic [eaddr_width_p-1:0]     redirect_pc_o,
    input  logic                         redirect_yumi_i
);
    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;

    typedef enum logic {e_run, e_redirect} state_e;

    function automatic bp_fe_instr_scan_class_e scan_class(input logic [instr_width_p-1:0] instr);
        bp_fe_instr_scan_class_e cls;
        cls = e_default;
        if (instr[1:0] == 2'b11) begin
            unique case (instr[6:0])
                7'b1101111: cls = e_rvi_jal;
                7'b1100111: cls = e_rvi_jalr;
                7'b1100011: cls = e_rvi_branch;
                default:    cls = e_default;
            endcase
        end
        return cls;
    endfunction

    function automatic logic signed [20:0] scan_imm(input logic [instr_width_p-1:0] instr,
                                                   input bp_fe_instr_scan_class_e cls);
        logic signed [20:0] imm;
        unique case (cls)
            e_rvi_jal:    imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            e_rvi_branch: imm = {{8{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            e_rvi_jalr:   imm = {{9{instr[31]}}, instr[31:20]};
            default:      imm = '0;
        endcase
        return imm;
    endfunction

    // Sign-extend and add; the sum simply wraps at the address width.
    function automatic logic [eaddr_width_p-1:0] scan_target(input logic [eaddr_width_p-1:0] pc,
                                                            input logic signed [20:0] imm);
        return pc + {{(eaddr_width_p-21){imm[20]}}, imm};
    endfunction

    state_e                   state_r, state_n;
    logic [ptr_w_lp-1:0]      rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0]      count_r;
    logic [eaddr_width_p-1:0] pc_mem [fifo_els_p];
    logic [instr_width_p-1:0] instr_mem [fifo_els_p];
    logic [eaddr_width_p-1:0] target_r;

    bp_fe_instr_scan_class_e  head_class;
    logic signed [20:0]       head_imm;
    logic                     enq, deq, take;

    assign instr_pc_o         = pc_mem[rd_ptr_r];
    assign instr_o            = instr_mem[rd_ptr_r];
    assign head_class         = scan_class(instr_o);
    assign head_imm           = scan_imm(instr_o, head_class);
    assign instr_class_o      = instr_v_o ? head_class : e_default;
    assign instr_compressed_o = instr_v_o & (instr_o[1:0] != 2'b11);
    assign redirect_pc_o      = target_r;

    assign enq  = fetch_v_i & fetch_ready_o;
    assign deq  = instr_yumi_i & instr_v_o;
    assign take = deq & ((head_class == e_rvi_jal) | ((head_class == e_rvi_branch) & head_imm[20]));

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) state_r <= e_run;
        else                    state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_run:      if (take) state_n = e_redirect;
            e_redirect: if (redirect_yumi_i) state_n = e_run;
            default:    state_n = e_run;
        endcase
    end

    always_comb begin
        fetch_ready_o = 1'b0;
        instr_v_o     = 1'b0;
        redirect_v_o  = 1'b0;
        unique case (state_r)
            e_run: begin
                fetch_ready_o = (count_r < cnt_w_lp'(fifo_els_p));
                instr_v_o     = (count_r != '0);
            end
            e_redirect: redirect_v_o = 1'b1;
            default: ;
        endcase
    end

    // A taken redirect drops everything behind the head, including a same-cycle enqueue.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i || take) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
            if (deq) rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
            if (enq && !deq)      count_r <= count_r + cnt_w_lp'(1);
            else if (!enq && deq) count_r <= count_r - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)               target_r <= '0;
        else if (take && !flush_i) target_r <= scan_target(instr_pc_o, head_imm);
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc_mem[wr_ptr_r]    <= fetch_pc_i;
            instr_mem[wr_ptr_r] <= fetch_instr_i;
        end
    end
endmodule

// File: tb/tb_bp_fe_scan_sequencer.sv
// Bench for bp_fe_scan_sequencer: decode/redirect vector table plus hand-built queue, flush and reset sequences.
module tb_bp_fe_scan_sequencer;
    import bp_fe_scan_pkg::*;

    localparam int EW = 64;
    localparam int IW = 32;
    localparam int FE = 4;

    logic          clk_i = 1'b0;
    logic          reset_i, flush_i, fetch_v_i, instr_yumi_i, redirect_yumi_i;
    logic [EW-1:0] fetch_pc_i, instr_pc_o, redirect_pc_o;
    logic [IW-1:0] fetch_instr_i, instr_o;
    logic          fetch_ready_o, instr_v_o, instr_compressed_o, redirect_v_o;
    bp_fe_instr_scan_class_e instr_class_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0]             pc;
        logic [31:0]             instr;
        bp_fe_instr_scan_class_e cls;
        logic                    comp;
        logic                    redir;
        logic [63:0]             tgt;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[8];

    bp_fe_scan_sequencer #(
        .eaddr_width_p(EW),
        .instr_width_p(IW),
        .fifo_els_p(FE)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .fetch_v_i(fetch_v_i),
        .fetch_pc_i(fetch_pc_i),
        .fetch_instr_i(fetch_instr_i),
        .fetch_ready_o(fetch_ready_o),
        .instr_v_o(instr_v_o),
        .instr_pc_o(instr_pc_o),
        .instr_o(instr_o),
        .instr_class_o(instr_class_o),
        .instr_compressed_o(instr_compressed_o),
        .instr_yumi_i(instr_yumi_i),
        .redirect_v_o(redirect_v_o),
        .redirect_pc_o(redirect_pc_o),
        .redirect_yumi_i(redirect_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded bound", $time);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [63:0] pc, input logic [31:0] instr,
                                input bp_fe_instr_scan_class_e cls, input logic comp,
                                input logic redir, input logic [63:0] tgt);
        vec_t v;
        v.pc = pc; v.instr = instr; v.cls = cls; v.comp = comp; v.redir = redir; v.tgt = tgt;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_fetch(input vec_t v, input logic accept);
        chk("fetch_ready", 64'(fetch_ready_o), 64'(accept));
        fetch_v_i     = 1'b1;
        fetch_pc_i    = v.pc;
        fetch_instr_i = v.instr;
        if (accept) sb.push_back(v);
    endtask

    task automatic pop_head(input string nm);
        vec_t e;
        chk({nm, "_v"}, 64'(instr_v_o), 64'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_sb: head pc %h present, expected no entry", nm, instr_pc_o);
        end else begin
            e = sb.pop_front();
            chk({nm, "_pc"}, instr_pc_o, e.pc);
            chk({nm, "_instr"}, 64'(instr_o), 64'(e.instr));
            chk({nm, "_class"}, 64'(instr_class_o), 64'(e.cls));
            chk({nm, "_comp"}, 64'(instr_compressed_o), 64'(e.comp));
        end
    endtask

    task automatic redirect_handshake(input string nm, input logic [63:0] tgt);
        chk({nm, "_rv"}, 64'(redirect_v_o), 64'd1);
        chk({nm, "_rpc"}, redirect_pc_o, tgt);
        chk({nm, "_iv_blk"}, 64'(instr_v_o), 64'd0);
        chk({nm, "_rdy_blk"}, 64'(fetch_ready_o), 64'd0);
        tick();
        chk({nm, "_rv_hold"}, 64'(redirect_v_o), 64'd1);
        chk({nm, "_rpc_hold"}, redirect_pc_o, tgt);
        redirect_yumi_i = 1'b1;
        tick();
        redirect_yumi_i = 1'b0;
        chk({nm, "_rv_done"}, 64'(redirect_v_o), 64'd0);
        chk({nm, "_rdy_done"}, 64'(fetch_ready_o), 64'd1);
    endtask

    initial begin
        vecs[0] = mk(64'h1000, 32'h00000013, e_default,    1'b0, 1'b0, 64'h0);
        vecs[1] = mk(64'h2000, 32'h0080006F, e_rvi_jal,    1'b0, 1'b1, 64'h2008);
        vecs[2] = mk(64'h3010, 32'hFE000EE3, e_rvi_branch, 1'b0, 1'b1, 64'h300C);
        vecs[3] = mk(64'h3010, 32'h00000463, e_rvi_branch, 1'b0, 1'b0, 64'h0);
        vecs[4] = mk(64'hFFFF_FFFF_FFFF_FFFC, 32'h0080006F, e_rvi_jal, 1'b0, 1'b1, 64'h4);
        vecs[5] = mk(64'h4000, 32'h000080E7, e_rvi_jalr,   1'b0, 1'b0, 64'h0);
        vecs[6] = mk(64'h4100, 32'h00004501, e_default,    1'b1, 1'b0, 64'h0);
        vecs[7] = mk(64'h5000, 32'hFFDFF06F, e_rvi_jal,    1'b0, 1'b1, 64'h4FFC);

        reset_i = 1'b1; flush_i = 1'b0; fetch_v_i = 1'b0; instr_yumi_i = 1'b0;
        redirect_yumi_i = 1'b0; fetch_pc_i = '0; fetch_instr_i = '0;
        repeat (2) tick();
        reset_i = 1'b0;
        chk("rst_ready", 64'(fetch_ready_o), 64'd1);
        chk("rst_iv", 64'(instr_v_o), 64'd0);
        chk("rst_rv", 64'(redirect_v_o), 64'd0);
        chk("rst_rpc", redirect_pc_o, 64'd0);
        chk("rst_class", 64'(instr_class_o), 64'(e_default));

        // Single-entry decode and redirect vectors
        for (int i = 0; i < 8; i++) begin
            chk("vec_idle_iv", 64'(instr_v_o), 64'd0);
            drive_fetch(vecs[i], 1'b1);
            tick();
            fetch_v_i = 1'b0;
            pop_head("vec");
            instr_yumi_i = 1'b1;
            tick();
            instr_yumi_i = 1'b0;
            if (vecs[i].redir) redirect_handshake("vec", vecs[i].tgt);
            else               chk("vec_no_redir", 64'(redirect_v_o), 64'd0);
        end

        // jal with a wrong-path entry queued behind it
        drive_fetch(vecs[1], 1'b1);
        tick();
        drive_fetch(mk(64'h2004, 32'h00100093, e_default, 1'b0, 1'b0, 64'h0), 1'b1);
        tick();
        fetch_v_i = 1'b0;
        pop_head("wp");
        instr_yumi_i = 1'b1;
        tick();
        instr_yumi_i = 1'b0;
        sb.delete();
        redirect_handshake("wp", 64'h2008);
        chk("wp_discarded", 64'(instr_v_o), 64'd0);

        // Fill to full, drop the fifth word, then drain in order
        for (int i = 0; i < FE; i++) begin
            drive_fetch(mk(64'h100 + 64'(4 * i), 32'h00000013 + 32'(i << 20), e_default, 1'b0, 1'b0, 64'h0), 1'b1);
            tick();
        end
        drive_fetch(mk(64'h110, 32'h00500013, e_default, 1'b0, 1'b0, 64'h0), 1'b0);
        tick();
        fetch_v_i = 1'b0;
        chk("full_ready", 64'(fetch_ready_o), 64'd0);
        pop_head("fill");
        instr_yumi_i = 1'b1;
        chk("full_deq_ready", 64'(fetch_ready_o), 64'd0);
        tick();
        instr_yumi_i = 1'b0;
        chk("after_deq_ready", 64'(fetch_ready_o), 64'd1);
        for (int i = 1; i < FE; i++) begin
            pop_head("fill");
            instr_yumi_i = 1'b1;
            tick();
            instr_yumi_i = 1'b0;
        end
        chk("fifth_dropped", 64'(instr_v_o), 64'd0);

        // Simultaneous enqueue and dequeue
        drive_fetch(mk(64'h600, 32'h00A00013, e_default, 1'b0, 1'b0, 64'h0), 1'b1);
        tick();
        pop_head("simul");
        drive_fetch(mk(64'h604, 32'h00B00013, e_default, 1'b0, 1'b0, 64'h0), 1'b1);
        instr_yumi_i = 1'b1;
        tick();
        fetch_v_i = 1'b0;
        pop_head("simul");
        tick();
        instr_yumi_i = 1'b0;
        chk("simul_empty", 64'(instr_v_o), 64'd0);

        // Flush while in REDIRECT after a jal with three followers
        drive_fetch(mk(64'h7000, 32'h0080006F, e_rvi_jal, 1'b0, 1'b1, 64'h7008), 1'b1);
        tick();
        for (int i = 1; i < FE; i++) begin
            drive_fetch(mk(64'h7000 + 64'(4 * i), 32'h00000013, e_default, 1'b0, 1'b0, 64'h0), 1'b1);
            tick();
        end
        fetch_v_i = 1'b0;
        pop_head("flr");
        instr_yumi_i = 1'b1;
        tick();
        instr_yumi_i = 1'b0;
        sb.delete();
        chk("flr_rv", 64'(redirect_v_o), 64'd1);
        chk("flr_rpc", redirect_pc_o, 64'h7008);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flr_rv_off", 64'(redirect_v_o), 64'd0);
        chk("flr_iv", 64'(instr_v_o), 64'd0);
        chk("flr_ready", 64'(fetch_ready_o), 64'd1);

        // Flush on the same cycle a jal is consumed and a word arrives
        drive_fetch(vecs[1], 1'b1);
        tick();
        pop_head("flt");
        fetch_pc_i = 64'h2004; fetch_instr_i = 32'h00000013;
        instr_yumi_i = 1'b1;
        flush_i = 1'b1;
        tick();
        instr_yumi_i = 1'b0; flush_i = 1'b0; fetch_v_i = 1'b0;
        chk("flt_rv", 64'(redirect_v_o), 64'd0);
        chk("flt_iv", 64'(instr_v_o), 64'd0);
        chk("flt_ready", 64'(fetch_ready_o), 64'd1);

        // Reset during REDIRECT
        drive_fetch(vecs[4], 1'b1);
        tick();
        fetch_v_i = 1'b0;
        pop_head("rr");
        instr_yumi_i = 1'b1;
        tick();
        instr_yumi_i = 1'b0;
        chk("rr_rv", 64'(redirect_v_o), 64'd1);
        chk("rr_rpc", redirect_pc_o, 64'h4);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rr_rv_off", 64'(redirect_v_o), 64'd0);
        chk("rr_rpc_clr", redirect_pc_o, 64'd0);
        chk("rr_iv", 64'(instr_v_o), 64'd0);
        chk("rr_ready", 64'(fetch_ready_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
